// File: rtl/reg_file_pkg.sv
// Shared widths, constants and types for the architectural register file.
package reg_file_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 2;
  localparam int unsigned NREG = 1 << AW;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [AW-1:0]   addr_t;
  typedef logic [CW-1:0]   pend_t;

  localparam word_t ZERO_WORD    = '0;
  localparam addr_t RegAddrZero  = '0;
  localparam pend_t PEND_MAX     = '1;
  localparam logic  True         = 1'b1;
  localparam logic  False        = 1'b0;
  localparam logic  WriteEnable  = 1'b1;
  localparam logic  WriteDisable = 1'b0;

endpackage

// File: rtl/reg_file_if.sv
// Writeback, read-port and issue signals between the pipeline and the register file.
interface reg_file_if;
  import reg_file_pkg::*;

  logic  rdy;
  logic  wb_rdy;
  word_t wb_rd_data;
  addr_t wb_rd_addr;
  logic  wb_rd_enable;
  addr_t id_rs1_addr;
  addr_t id_rs2_addr;
  word_t rs1_data;
  word_t rs2_data;
  logic  rs1_busy;
  logic  rs2_busy;
  logic  issue_enable;
  addr_t issue_rd_addr;
  logic  issue_ready;
  logic  flush;

  modport master (
    output rdy, wb_rdy, wb_rd_data, wb_rd_addr, wb_rd_enable,
    output id_rs1_addr, id_rs2_addr, issue_enable, issue_rd_addr, flush,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready
  );

  modport slave (
    input  rdy, wb_rdy, wb_rd_data, wb_rd_addr, wb_rd_enable,
    input  id_rs1_addr, id_rs2_addr, issue_enable, issue_rd_addr, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready
  );

endinterface

// File: rtl/reg_file_wb_scoreboard.sv
// Per-register pending-write counters; answers "is this source still owed" and
// "may another writer to this destination be dispatched".
module wb_scoreboard
  import reg_file_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  iss_i,
  input  logic  wr_i,
  input  logic  flush_i,
  input  addr_t iss_addr_i,
  input  addr_t wr_addr_i,
  input  addr_t rs1_addr_i,
  input  addr_t rs2_addr_i,
  output logic  issue_ready_o,
  output logic  rs1_busy_o,
  output logic  rs2_busy_o
);

  pend_t pend_q [NREG];
  pend_t pend_d [NREG];
  logic  hit1_c;
  logic  hit2_c;

  always_comb begin
    pend_d = pend_q;
    for (int unsigned r = 1; r < NREG; r++) begin
      logic inc;
      logic dec;
      inc = iss_i && (iss_addr_i == AW'(r));
      dec = wr_i && (wr_addr_i == AW'(r));
      // A writeback retiring the same register as a new issue nets to zero.
      if (inc && !dec) begin
        pend_d[AW'(r)] = pend_q[AW'(r)] + CW'(1);
      end else if (dec && !inc && (pend_q[AW'(r)] != '0)) begin
        pend_d[AW'(r)] = pend_q[AW'(r)] - CW'(1);
      end
    end
    pend_d[RegAddrZero] = '0;
    if (flush_i) begin
      pend_d = '{default: '0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '{default: '0};
    end else begin
      pend_q <= pend_d;
    end
  end

  assign issue_ready_o = (iss_addr_i == RegAddrZero)
                       | (pend_q[iss_addr_i] != PEND_MAX)
                       | (wr_i & (wr_addr_i == iss_addr_i));

  // A same-cycle writeback retires one owed write; a zero count stays zero.
  assign hit1_c = wr_i && (wr_addr_i == rs1_addr_i);
  assign hit2_c = wr_i && (wr_addr_i == rs2_addr_i);

  assign rs1_busy_o = (rs1_addr_i == RegAddrZero) ? False :
                      (pend_q[rs1_addr_i] != '0) && !(hit1_c && (pend_q[rs1_addr_i] == CW'(1)));
  assign rs2_busy_o = (rs2_addr_i == RegAddrZero) ? False :
                      (pend_q[rs2_addr_i] != '0) && !(hit2_c && (pend_q[rs2_addr_i] == CW'(1)));

endmodule

// File: rtl/reg_file.sv
// Architectural register file: writeback port, two bypassed combinational read
// ports, and the pending-write scoreboard used by ID for RAW stalls.
module reg_file
  import reg_file_pkg::*;
(
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  logic  wr_c;
  logic  iss_c;
  logic  flush_c;
  logic  issue_ready_c;
  logic  rs1_busy_c;
  logic  rs2_busy_c;
  word_t regs_q [NREG];

  assign wr_c    = bus.rdy & bus.wb_rdy & (bus.wb_rd_enable == WriteEnable)
                 & (bus.wb_rd_addr != RegAddrZero);
  assign iss_c   = bus.rdy & bus.issue_enable & issue_ready_c
                 & (bus.issue_rd_addr != RegAddrZero);
  assign flush_c = bus.rdy & bus.flush;

  // x0 is never a write target, so its entry stays at the reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '{default: ZERO_WORD};
    end else if (wr_c) begin
      regs_q[bus.wb_rd_addr] <= bus.wb_rd_data;
    end
  end

  always_comb begin
    bus.rs1_data = regs_q[bus.id_rs1_addr];
    if (wr_c && (bus.wb_rd_addr == bus.id_rs1_addr)) begin
      bus.rs1_data = bus.wb_rd_data;
    end
    if (bus.id_rs1_addr == RegAddrZero) begin
      bus.rs1_data = ZERO_WORD;
    end
    bus.rs2_data = regs_q[bus.id_rs2_addr];
    if (wr_c && (bus.wb_rd_addr == bus.id_rs2_addr)) begin
      bus.rs2_data = bus.wb_rd_data;
    end
    if (bus.id_rs2_addr == RegAddrZero) begin
      bus.rs2_data = ZERO_WORD;
    end
  end

  wb_scoreboard u_sb (
    .clk           (clk),
    .rst           (rst),
    .iss_i         (iss_c),
    .wr_i          (wr_c),
    .flush_i       (flush_c),
    .iss_addr_i    (bus.issue_rd_addr),
    .wr_addr_i     (bus.wb_rd_addr),
    .rs1_addr_i    (bus.id_rs1_addr),
    .rs2_addr_i    (bus.id_rs2_addr),
    .issue_ready_o (issue_ready_c),
    .rs1_busy_o    (rs1_busy_c),
    .rs2_busy_o    (rs2_busy_c)
  );

  assign bus.issue_ready = issue_ready_c;
  assign bus.rs1_busy    = rs1_busy_c;
  assign bus.rs2_busy    = rs2_busy_c;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a randomized
// back-to-back run against a behavioural model, all via an expectation queue.
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_if bus ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sbq [$];
  logic [31:0] e;

  logic [31:0] mregs [32];
  int          mpend [32];

  task automatic set_idle();
    bus.rdy           = 1'b1;
    bus.wb_rdy        = 1'b0;
    bus.wb_rd_enable  = 1'b0;
    bus.wb_rd_addr    = '0;
    bus.wb_rd_data    = '0;
    bus.issue_enable  = 1'b0;
    bus.issue_rd_addr = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic drive_wb(input int a, input logic [31:0] d);
    bus.wb_rdy       = 1'b1;
    bus.wb_rd_enable = 1'b1;
    bus.wb_rd_addr   = AW'(a);
    bus.wb_rd_data   = d;
  endtask

  task automatic drive_issue(input int a);
    bus.issue_enable  = 1'b1;
    bus.issue_rd_addr = AW'(a);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    bus.id_rs1_addr = AW'(5);
    bus.id_rs2_addr = AW'(0);
    bus.issue_rd_addr = AW'(5);
    sbq.push_back(32'h0); sbq.push_back(32'h0); sbq.push_back(32'h1);
    @(negedge clk); @(negedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (bus.rs1_data !== e) begin errors++; $display("FAIL reset_rs1_data: got %h expected %h", bus.rs1_data, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL reset_rs1_busy: got %h expected %h", bus.rs1_busy, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.issue_ready} !== e) begin errors++; $display("FAIL reset_issue_ready: got %h expected %h", bus.issue_ready, e); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    set_idle();
    drive_wb(5, 32'h1234_5678);
    bus.id_rs1_addr = AW'(1);
    @(negedge clk);
    set_idle();
    bus.id_rs1_addr = AW'(5);
    sbq.push_back(32'h1234_5678); sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); checks++;
    if (bus.rs1_data !== e) begin errors++; $display("FAIL write_read_data: got %h expected %h", bus.rs1_data, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL write_read_busy: got %h expected %h", bus.rs1_busy, e); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    set_idle();
    drive_wb(0, 32'hFFFF_FFFF);
    drive_issue(0);
    bus.id_rs1_addr = AW'(0);
    sbq.push_back(32'h0); sbq.push_back(32'h1);
    #1;
    e = sbq.pop_front(); checks++;
    if (bus.rs1_data !== e) begin errors++; $display("FAIL x0_write_bypass: got %h expected %h", bus.rs1_data, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.issue_ready} !== e) begin errors++; $display("FAIL x0_issue_ready: got %h expected %h", bus.issue_ready, e); end
    @(negedge clk);
    set_idle();
    bus.id_rs1_addr = AW'(0);
    sbq.push_back(32'h0); sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); checks++;
    if (bus.rs1_data !== e) begin errors++; $display("FAIL x0_read_after: got %h expected %h", bus.rs1_data, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL x0_busy: got %h expected %h", bus.rs1_busy, e); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    set_idle();
    bus.id_rs1_addr = AW'(7);
    bus.id_rs2_addr = AW'(7);
    sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); checks++;
    if (bus.rs2_data !== e) begin errors++; $display("FAIL bypass_pre: got %h expected %h", bus.rs2_data, e); end
    @(negedge clk);
    drive_wb(7, 32'hA5A5_A5A5);
    sbq.push_back(32'hA5A5_A5A5); sbq.push_back(32'hA5A5_A5A5);
    #1;
    e = sbq.pop_front(); checks++;
    if (bus.rs2_data !== e) begin errors++; $display("FAIL bypass_rs2: got %h expected %h", bus.rs2_data, e); end
    e = sbq.pop_front(); checks++;
    if (bus.rs1_data !== e) begin errors++; $display("FAIL bypass_rs1: got %h expected %h", bus.rs1_data, e); end
    // wb_rdy low must neither bypass nor commit.
    @(negedge clk);
    drive_wb(7, 32'h0000_0011);
    bus.wb_rdy = 1'b0;
    sbq.push_back(32'hA5A5_A5A5);
    #1;
    e = sbq.pop_front(); checks++;
    if (bus.rs2_data !== e) begin errors++; $display("FAIL no_wb_rdy_bypass: got %h expected %h", bus.rs2_data, e); end
    @(negedge clk);
    set_idle();
    sbq.push_back(32'hA5A5_A5A5);
    #1;
    e = sbq.pop_front(); checks++;
    if (bus.rs2_data !== e) begin errors++; $display("FAIL no_wb_rdy_commit: got %h expected %h", bus.rs2_data, e); end
  endtask

  task automatic test_scoreboard();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_idle();
      drive_issue(3);
      bus.id_rs1_addr = AW'(3);
      sbq.push_back(32'h1);
      #1;
      e = sbq.pop_front(); checks++;
      if ({31'b0, bus.issue_ready} !== e) begin errors++; $display("FAIL sb_issue_ready_%0d: got %h expected %h", i, bus.issue_ready, e); end
    end
    // Counter saturated: this dispatch must be refused.
    @(negedge clk);
    sbq.push_back(32'h1); sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL sb_busy_full: got %h expected %h", bus.rs1_busy, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.issue_ready} !== e) begin errors++; $display("FAIL sb_ready_full: got %h expected %h", bus.issue_ready, e); end
    @(negedge clk);
    drive_wb(3, 32'h0000_0033);
    sbq.push_back(32'h1); sbq.push_back(32'h1); sbq.push_back(32'h0000_0033);
    #1;
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.issue_ready} !== e) begin errors++; $display("FAIL sb_ready_wr_same: got %h expected %h", bus.issue_ready, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL sb_busy_wr_same: got %h expected %h", bus.rs1_busy, e); end
    e = sbq.pop_front(); checks++;
    if (bus.rs1_data !== e) begin errors++; $display("FAIL sb_data_wr_same: got %h expected %h", bus.rs1_data, e); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_idle();
      drive_wb(3, 32'h0000_0040 + 32'(i));
      sbq.push_back((i == 2) ? 32'h0 : 32'h1);
      #1;
      e = sbq.pop_front(); checks++;
      if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL sb_drain_%0d: got %h expected %h", i, bus.rs1_busy, e); end
    end
    @(negedge clk);
    set_idle();
    bus.issue_rd_addr = AW'(3);
    sbq.push_back(32'h0); sbq.push_back(32'h1);
    #1;
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL sb_drained_busy: got %h expected %h", bus.rs1_busy, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.issue_ready} !== e) begin errors++; $display("FAIL sb_drained_ready: got %h expected %h", bus.issue_ready, e); end
    // Extra writeback at zero count must not wrap the counter.
    @(negedge clk);
    drive_wb(3, 32'h0000_0050);
    sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL sb_wr_at_zero_busy: got %h expected %h", bus.rs1_busy, e); end
    @(negedge clk);
    set_idle();
    bus.issue_rd_addr = AW'(3);
    sbq.push_back(32'h0); sbq.push_back(32'h1);
    #1;
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL sb_no_underflow_busy: got %h expected %h", bus.rs1_busy, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.issue_ready} !== e) begin errors++; $display("FAIL sb_no_underflow_ready: got %h expected %h", bus.issue_ready, e); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_idle();
      drive_issue(9);
    end
    @(negedge clk);
    set_idle();
    drive_wb(9, 32'h0000_0042);
    drive_issue(10);
    bus.flush = 1'b1;
    bus.id_rs1_addr = AW'(9);
    bus.id_rs2_addr = AW'(10);
    sbq.push_back(32'h1);
    #1;
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL flush_cycle_busy: got %h expected %h", bus.rs1_busy, e); end
    @(negedge clk);
    set_idle();
    sbq.push_back(32'h0000_0042); sbq.push_back(32'h0); sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); checks++;
    if (bus.rs1_data !== e) begin errors++; $display("FAIL flush_wr_data: got %h expected %h", bus.rs1_data, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL flush_clears_busy: got %h expected %h", bus.rs1_busy, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs2_busy} !== e) begin errors++; $display("FAIL flush_drops_issue: got %h expected %h", bus.rs2_busy, e); end
  endtask

  task automatic test_rdy_low();
    @(negedge clk);
    set_idle();
    drive_issue(12);
    @(negedge clk);
    set_idle();
    bus.rdy = 1'b0;
    drive_wb(4, 32'hDEAD_BEEF);
    drive_issue(4);
    bus.flush = 1'b1;
    bus.id_rs1_addr = AW'(4);
    bus.id_rs2_addr = AW'(12);
    sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); checks++;
    if (bus.rs1_data !== e) begin errors++; $display("FAIL rdy_low_no_bypass: got %h expected %h", bus.rs1_data, e); end
    @(negedge clk);
    set_idle();
    sbq.push_back(32'h0); sbq.push_back(32'h0); sbq.push_back(32'h1);
    #1;
    e = sbq.pop_front(); checks++;
    if (bus.rs1_data !== e) begin errors++; $display("FAIL rdy_low_regs: got %h expected %h", bus.rs1_data, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL rdy_low_pend: got %h expected %h", bus.rs1_busy, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs2_busy} !== e) begin errors++; $display("FAIL rdy_low_flush: got %h expected %h", bus.rs2_busy, e); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_idle();
      drive_issue((i == 2) ? 8 : 6);
    end
    @(negedge clk);
    set_idle();
    bus.id_rs1_addr = AW'(6);
    bus.id_rs2_addr = AW'(8);
    bus.issue_rd_addr = AW'(6);
    sbq.push_back(32'h1); sbq.push_back(32'h1);
    #1;
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL pre_rst_busy1: got %h expected %h", bus.rs1_busy, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs2_busy} !== e) begin errors++; $display("FAIL pre_rst_busy2: got %h expected %h", bus.rs2_busy, e); end
    #1 rst = 1'b0;
    sbq.push_back(32'h0); sbq.push_back(32'h0); sbq.push_back(32'h1);
    #1;
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL async_rst_busy1: got %h expected %h", bus.rs1_busy, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.rs2_busy} !== e) begin errors++; $display("FAIL async_rst_busy2: got %h expected %h", bus.rs2_busy, e); end
    e = sbq.pop_front(); checks++;
    if ({31'b0, bus.issue_ready} !== e) begin errors++; $display("FAIL async_rst_ready: got %h expected %h", bus.issue_ready, e); end
    bus.id_rs2_addr = AW'(5);
    sbq.push_back(32'h0);
    #1;
    e = sbq.pop_front(); checks++;
    if (bus.rs2_data !== e) begin errors++; $display("FAIL async_rst_regs: got %h expected %h", bus.rs2_data, e); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    int wa, ia, a1, a2;
    logic [31:0] wd;
    logic mwr, miss, mfl, mready;
    for (int r = 0; r < 32; r++) begin
      mregs[r] = '0;
      mpend[r] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      set_idle();
      bus.rdy          = ($urandom_range(7) != 0);
      bus.wb_rdy       = ($urandom_range(3) != 0);
      bus.wb_rd_enable = ($urandom_range(3) != 0);
      wa = $urandom_range(3);
      ia = $urandom_range(3);
      a1 = $urandom_range(3);
      a2 = $urandom_range(3);
      wd = $urandom;
      bus.wb_rd_addr    = AW'(wa);
      bus.wb_rd_data    = wd;
      bus.issue_enable  = ($urandom_range(1) != 0);
      bus.issue_rd_addr = AW'(ia);
      bus.flush         = ($urandom_range(15) == 0);
      bus.id_rs1_addr   = AW'(a1);
      bus.id_rs2_addr   = AW'(a2);

      mwr    = bus.rdy && bus.wb_rdy && bus.wb_rd_enable && (wa != 0);
      mready = (ia == 0) || (mpend[ia] != 3) || (mwr && (wa == ia));
      miss   = bus.rdy && bus.issue_enable && mready && (ia != 0);
      mfl    = bus.rdy && bus.flush;
      sbq.push_back((a1 == 0) ? 32'h0 : (mwr && wa == a1) ? wd : mregs[a1]);
      sbq.push_back((a2 == 0) ? 32'h0 : (mwr && wa == a2) ? wd : mregs[a2]);
      sbq.push_back({31'b0, (a1 != 0) && ((mpend[a1] - ((mwr && wa == a1) ? 1 : 0)) > 0)});
      sbq.push_back({31'b0, (a2 != 0) && ((mpend[a2] - ((mwr && wa == a2) ? 1 : 0)) > 0)});
      sbq.push_back({31'b0, mready});
      #1;
      e = sbq.pop_front(); checks++;
      if (bus.rs1_data !== e) begin errors++; $display("FAIL b2b_rs1_data cyc %0d: got %h expected %h", cyc, bus.rs1_data, e); end
      e = sbq.pop_front(); checks++;
      if (bus.rs2_data !== e) begin errors++; $display("FAIL b2b_rs2_data cyc %0d: got %h expected %h", cyc, bus.rs2_data, e); end
      e = sbq.pop_front(); checks++;
      if ({31'b0, bus.rs1_busy} !== e) begin errors++; $display("FAIL b2b_rs1_busy cyc %0d: got %h expected %h", cyc, bus.rs1_busy, e); end
      e = sbq.pop_front(); checks++;
      if ({31'b0, bus.rs2_busy} !== e) begin errors++; $display("FAIL b2b_rs2_busy cyc %0d: got %h expected %h", cyc, bus.rs2_busy, e); end
      e = sbq.pop_front(); checks++;
      if ({31'b0, bus.issue_ready} !== e) begin errors++; $display("FAIL b2b_issue_ready cyc %0d: got %h expected %h", cyc, bus.issue_ready, e); end

      if (mwr) mregs[wa] = wd;
      if (mfl) begin
        for (int r = 0; r < 32; r++) mpend[r] = 0;
      end else if (!(miss && mwr && ia == wa)) begin
        if (miss) mpend[ia]++;
        if (mwr && mpend[wa] > 0) mpend[wa]--;
      end
    end
  endtask

  initial begin
    bus.id_rs1_addr = '0;
    bus.id_rs2_addr = '0;
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_scoreboard();
    test_flush();
    test_rdy_low();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file at the consumer end of the writeback interface. It accepts the `wb_rd_*` write from the MEM/WB pipeline register and serves two combinational read ports to the ID stage, with a same-cycle write bypass. A per-register pending-write scoreboard tells ID when a source operand is still owed by an in-flight instruction, so ID can stall on read-after-write hazards.

## Interface
- `XLEN`, 32: register width (matches `RegLen`).
- `AW`, 5: register address width (matches `RegAddrLen`); 2^AW registers.
- `CW`, 2: pending-counter width; at most 2^CW−1 in-flight writes per register.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rdy` in 1: global ready; low freezes all state.
- `wb_rdy` in 1: MEM/WB contents valid (`mem_wb_rdy`).
- `wb_rd_data` in XLEN: writeback data.
- `wb_rd_addr` in AW: writeback destination.
- `wb_rd_enable` in 1: writeback write enable.
- `id_rs1_addr`, `id_rs2_addr` in AW: source addresses.
- `rs1_data`, `rs2_data` out XLEN: source read data, combinational.
- `rs1_busy`, `rs2_busy` out 1: source still owed by an in-flight write.
- `issue_enable` in 1: ID dispatches an instruction that writes `issue_rd_addr`.
- `issue_rd_addr` in AW: destination of the dispatched instruction.
- `issue_ready` out 1: a dispatch to `issue_rd_addr` is accepted this cycle.
- `flush` in 1: branch mispredict; discard all in-flight destinations.

## Operation
- Write qualifier: `wr = rdy & wb_rdy & wb_rd_enable & (wb_rd_addr != 0)`.
- On a clock edge with `wr` high, `regs[wb_rd_addr] <= wb_rd_data`.
- x0 is never written and always reads 0.
- Read: `rsN_data` = 0 if the address is 0; else `wb_rd_data` if `wr` and `wb_rd_addr == rsN_addr` (bypass); else `regs[rsN_addr]`.
- Scoreboard: one CW-bit counter `pend[r]` per register, r≥1; `pend[0]` is constantly 0.
- Issue qualifier: `iss = rdy & issue_enable & issue_ready & (issue_rd_addr != 0)`.
- `issue_ready = (issue_rd_addr == 0) | (pend[issue_rd_addr] != 2^CW−1) | (wr & wb_rd_addr == issue_rd_addr)`.
- Counter update per register at the clock edge:
  - `iss` only: +1.
  - `wr` only: −1.
  - Both to the same register: unchanged.
- `wr` to a register whose `pend` is 0 writes data and leaves `pend` at 0; it never underflows.
- `rsN_busy = (pend[a] − (wr & wb_rd_addr == a)) != 0`, where `a = rsN_addr`. Always 0 for x0.
- `flush` (qualified by `rdy`): every `pend` ← 0; a same-cycle `iss` is dropped; a same-cycle `wr` still updates `regs`.
- `rdy` low: no register or counter update; combinational outputs keep tracking their inputs.

## Timing
- Reads and bypass are zero-latency combinational.
- Write data is visible through `regs` from the cycle after the write edge.
- Busy status reflects an issue from the cycle after `iss`, and reflects a writeback in the same cycle as `wr`.
- Reset (asynchronous, `rst` low): all `regs` = 0, all `pend` = 0.
  - While in reset: `rs1_data` = `rs2_data` = 0 unless bypassed, `rs1_busy` = `rs2_busy` = 0, `issue_ready` = 1.
  - Reset asserted mid-operation discards every in-flight count immediately.
- Release of reset is synchronous to `clk` upstream; the first update is on the first edge with `rst` high.

## Structure
- Shared package (`config.v` defines): `XLEN`, `AW`, `CW`, `ZERO_WORD`, `RegAddrZero`, `True`/`False`, `WriteEnable`/`WriteDisable`.
- One sub-module, `wb_scoreboard`, owns:
  - Inputs: the `pend` array, `iss`/`wr`/`flush`.
  - Outputs: `issue_ready` and a per-address busy lookup for the two read ports.
- `reg_file` owns the data array, the bypass logic and qualifier generation.

## Test plan
- Reset, write x5=0x1234_5678 with `wb_rdy`=1, next cycle read rs1=x5 → `rs1_data`=0x12345678, `rs1_busy`=0.
- Write x0=0xFFFF_FFFF → `rs1_data` for x0 stays 0; issue to x0 → `pend` unchanged, `issue_ready`=1.
- Same cycle: `wr` to x7=0xA5A5_A5A5 and rs2=x7 while `regs[7]`=0 → `rs2_data`=0xA5A5A5A5 that cycle.
- Issue x3 three times → `rs1_busy`(x3)=1 and `issue_ready`(x3)=0. Then `wr` x3 with a simultaneous issue x3 → accepted, pend stays 3. Then three writebacks → busy clears in the cycle of the third.
- Issue x9 twice, assert `flush` together with `wr` x9=0x42 → next cycle `pend[9]`=0, `rs1_data`(x9)=0x42.
- With `rdy`=0, drive `wr` and issue to x4 → no change in `regs[4]` or `pend[4]`. Assert `rst` low mid-sequence → all busy outputs drop to 0 immediately.
